// File: rtl/blk_reorder_pkg.sv
// Shared types and constants for the 8x8 block reorder buffer.
package blk_reorder_pkg;

  typedef enum logic [1:0] {
    RASTER    = 2'd0,
    TRANSPOSE = 2'd1,
    ZIGZAG    = 2'd2
  } mode_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int unsigned BLK_N = 64;

  // JPEG zigzag scan: entry k is the raster index of the k-th zigzag element.
  localparam logic [5:0] ZZ [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] transpose_idx(input logic [5:0] e);
    return {e[2:0], e[5:3]};
  endfunction

endpackage

// File: rtl/blk_reorder_ctrl_if.sv
// Byte-stream bundle for the block reorder buffer: raster input, reordered output.
interface blk_reorder_ctrl_if;
  // A byte moves on a rising clk edge where valid && ready; a source holding
  // valid keeps its data stable and never drops valid until that transfer.
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_8bx8.sv
// One 8x8-bit bank: synchronous write, registered read with one cycle latency.
module ram_8bx8 (
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] mem [0:7];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/blk_reorder_ctrl.sv
// Fill-then-drain 64-byte block buffer emitting raster, transposed or zigzag order.
module blk_reorder_ctrl
  import blk_reorder_pkg::*;
#(
  parameter bit ZZ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  output logic              busy,
  output state_t            dbg_state,
  blk_reorder_ctrl_if.slave bus
);

  state_t     state, state_nxt;
  mode_t      mode_q, mode_nxt, mode_dec;
  logic [5:0] wr_idx, wr_idx_nxt;
  logic [5:0] e_q, e_nxt;
  logic [5:0] rd_e;
  logic [5:0] src, zz_src;
  logic [2:0] sel_q, sel_nxt;
  logic       busy_q, busy_nxt;
  logic       ov_q, ov_nxt;
  logic       in_hs, out_hs;
  logic [2:0] ram_addr;
  logic [7:0] bank_we;
  logic [7:0] bank_dout [0:7];

  assign in_hs  = bus.in_valid && (state == FILL);
  assign out_hs = ov_q && bus.out_ready;

  always_comb begin
    mode_dec = RASTER;
    case (mode)
      2'd1:    mode_dec = TRANSPOSE;
      2'd2:    mode_dec = ZZ_EN ? ZIGZAG : RASTER;
      default: mode_dec = RASTER;
    endcase
  end

  // Element to address this cycle: advancing on the handshake keeps the read
  // one step ahead so the registered bank output lands with no bubble.
  always_comb begin
    rd_e = e_q;
    if (state == DRAIN && out_hs) rd_e = e_q + 6'd1;
  end

  generate
    if (ZZ_EN) begin : g_zz
      assign zz_src = ZZ[rd_e];
    end else begin : g_no_zz
      assign zz_src = rd_e;
    end
  endgenerate

  always_comb begin
    src = rd_e;
    case (mode_q)
      TRANSPOSE: src = transpose_idx(rd_e);
      ZIGZAG:    src = zz_src;
      default:   src = rd_e;
    endcase
  end

  always_comb begin
    ram_addr = (state == FILL) ? wr_idx[5:3] : src[5:3];
    bank_we  = '0;
    if (in_hs) bank_we[wr_idx[2:0]] = 1'b1;
  end

  generate
    for (genvar b = 0; b < 8; b++) begin : g_bank
      ram_8bx8 u_bank (
        .clk  (clk),
        .we   (bank_we[b]),
        .addr (ram_addr),
        .din  (bus.in_data),
        .dout (bank_dout[b])
      );
    end
  endgenerate

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    wr_idx_nxt = wr_idx;
    e_nxt      = e_q;
    sel_nxt    = sel_q;
    busy_nxt   = busy_q;
    ov_nxt     = ov_q;
    case (state)
      FILL: begin
        if (in_hs) begin
          wr_idx_nxt = wr_idx + 6'd1;
          if (wr_idx == 6'd0) begin
            mode_nxt = mode_dec;
            busy_nxt = 1'b1;
          end
          if (wr_idx == 6'd63) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        e_nxt   = rd_e;
        sel_nxt = src[2:0];
        if (!ov_q) begin
          ov_nxt = 1'b1;
        end else if (out_hs && e_q == 6'd63) begin
          ov_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          e_nxt     = 6'd0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      mode_q <= RASTER;
      wr_idx <= 6'd0;
      e_q    <= 6'd0;
      sel_q  <= 3'd0;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
      wr_idx <= wr_idx_nxt;
      e_q    <= e_nxt;
      sel_q  <= sel_nxt;
      busy_q <= busy_nxt;
      ov_q   <= ov_nxt;
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = bank_dout[sel_q];
  assign bus.out_last  = ov_q && (e_q == 6'd63);
  assign busy          = busy_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_blk_reorder_ctrl.sv
// Self-checking bench for blk_reorder_ctrl: block table, scoreboard, reset and back-to-back sequences.
module tb_blk_reorder_ctrl;
  import blk_reorder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode;
  logic       busy;
  state_t     dbg_state;

  blk_reorder_ctrl_if bus ();

  blk_reorder_ctrl #(.ZZ_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int t_last = -1;
  int out_cnt = 0;
  int blk_cnt = 0;
  int elem_i = 0;

  logic [8:0] exp_q[$];
  logic [5:0] zz_m [0:63];
  logic [7:0] cap [0:15][0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, want, cyc);
    end
  endtask

  function automatic logic [5:0] model_src(input logic [1:0] m, input int e);
    case (m)
      2'd1:    return 6'(((e % 8) * 8) + (e / 8));
      2'd2:    return zz_m[e];
      default: return 6'(e);
    endcase
  endfunction

  // downstream ready generator
  always @(posedge clk) begin
    #1;
    bus.out_ready = ($urandom_range(99) < rdy_pct);
  end

  // output monitor and scoreboard
  logic       prev_stall = 1'b0;
  logic       prev_ov = 1'b0;
  logic       post_last = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [8:0] ev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (post_last) begin
        check("post_last_valid", 32'(bus.out_valid), 32'd0);
        check("post_last_busy", 32'(busy), 32'd0);
        check("post_last_in_ready", 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid) begin
        check("drain_in_ready", 32'(bus.in_ready), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        if (!prev_ov && t_last >= 0) check("first_out_latency", 32'(cyc - t_last), 32'd2);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0d with no byte expected at cycle %0d", bus.out_data, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("out_last_data", 32'({bus.out_last, bus.out_data}), 32'(ev));
        end
        if (blk_cnt < 16) cap[blk_cnt][elem_i] = bus.out_data;
        elem_i = (elem_i + 1) % 64;
        out_cnt++;
        if (bus.out_last) begin
          blk_cnt++;
          elem_i = 0;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ov    = bus.out_valid;
      post_last  = bus.out_valid && bus.out_ready && bus.out_last;
    end else begin
      prev_stall = 1'b0;
      prev_ov    = 1'b0;
      post_last  = 1'b0;
      elem_i     = 0;
    end
  end

  // driver tasks
  task automatic send_block(input logic [1:0] m, input logic [7:0] base, input int gap_pct,
                            input bit toggle, input bit rnd);
    logic [7:0] d [0:63];
    logic       hs;
    int         n;
    int         g;
    for (int i = 0; i < 64; i++) d[i] = rnd ? 8'($urandom_range(255)) : 8'(base + i);
    for (int e = 0; e < 64; e++) exp_q.push_back({(e == 63), d[model_src(m, e)]});
    for (int i = 0; i < 64; i++) begin
      g = 0;
      while ($urandom_range(99) < gap_pct && g < 6) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(255));
        @(posedge clk);
        #1;
        g++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      mode = (i == 0 || !toggle) ? m : 2'($urandom_range(3));
      n = 0;
      hs = 1'b0;
      while (!hs && n < 600) begin
        @(negedge clk);
        hs = bus.in_ready;
        if (hs && i == 63) t_last = cyc;
        @(posedge clk);
        #1;
        n++;
      end
      if (!hs) begin
        total++;
        bad++;
        $display("FAIL in_handshake_timeout: byte %0d not accepted after %0d cycles", i, n);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bytes still expected, wanted 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] m;
    int         rdy;
    int         gap;
    bit         toggle;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e9;
    logic [7:0] e62;
  } vec_t;

  vec_t       tbl [0:5];
  logic [7:0] zz_pre [0:9];
  logic [7:0] tr_pre [0:9];

  initial begin : watchdog
    #600000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int k;
    int target;
    int n;

    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 1) begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz_m[k] = 6'(r * 8 + (s - r));
          k++;
        end
      end else begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_m[k] = 6'(r * 8 + (s - r));
          k++;
        end
      end
    end

    //             mode  rdy  gap tog  e1  e2  e9  e62
    tbl[0] = '{2'd0, 100,   0, 1'b0,  1,  2,  9, 62};
    tbl[1] = '{2'd1, 100,   0, 1'b1,  8, 16,  9, 55};
    tbl[2] = '{2'd2, 100,   0, 1'b1,  1,  8, 24, 62};
    tbl[3] = '{2'd3, 100,   0, 1'b0,  1,  2,  9, 62};
    tbl[4] = '{2'd0,  50,  30, 1'b1,  1,  2,  9, 62};
    tbl[5] = '{2'd2,  50,  30, 1'b1,  1,  8, 24, 62};
    zz_pre = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    tr_pre = '{0, 8, 16, 24, 32, 40, 48, 56, 1, 9};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    mode          = 2'd0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FILL));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table of blocks, sent back to back
    for (int r = 0; r < 6; r++) begin
      rdy_pct = tbl[r].rdy;
      send_block(tbl[r].m, 8'd0, tbl[r].gap, tbl[r].toggle, 1'b0);
    end
    wait_drain();
    check("blocks_after_table", 32'(blk_cnt), 32'd6);
    for (int r = 0; r < 6; r++) begin
      check("spot_e0", 32'(cap[r][0]), 32'd0);
      check("spot_e1", 32'(cap[r][1]), 32'(tbl[r].e1));
      check("spot_e2", 32'(cap[r][2]), 32'(tbl[r].e2));
      check("spot_e9", 32'(cap[r][9]), 32'(tbl[r].e9));
      check("spot_e62", 32'(cap[r][62]), 32'(tbl[r].e62));
      check("spot_e63", 32'(cap[r][63]), 32'd63);
    end
    for (int i = 0; i < 10; i++) begin
      check("zigzag_prefix", 32'(cap[2][i]), 32'(zz_pre[i]));
      check("transpose_prefix", 32'(cap[1][i]), 32'(tr_pre[i]));
    end

    // reset in the middle of a drain
    rdy_pct = 100;
    target = out_cnt + 20;
    send_block(2'd0, 8'd0, 0, 1'b0, 1'b0);
    n = 0;
    while (out_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reached_20_outputs", 32'(out_cnt >= target), 32'd1);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_last", 32'(bus.out_last), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(FILL));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_rst_valid", 32'(bus.out_valid), 32'd0);
    send_block(2'd0, 8'd100, 0, 1'b0, 1'b0);
    wait_drain();
    check("fresh_first", 32'(cap[6][0]), 32'd100);
    check("fresh_mid", 32'(cap[6][31]), 32'd131);
    check("fresh_last", 32'(cap[6][63]), 32'd163);

    // back-to-back transpose then zigzag, random data, mode toggled mid-fill
    rdy_pct = 70;
    send_block(2'd1, 8'd0, 20, 1'b1, 1'b1);
    send_block(2'd2, 8'd0, 20, 1'b1, 1'b1);
    wait_drain();
    check("blocks_total", 32'(blk_cnt), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
